// File: rtl/fm_port_arbiter.sv
// fm_port_arbiter
//   Shares one feature-map memory port between NUM_REQ engines (conv1, dws,
//   skip-fill, dw buffer path). A registered round-robin arbiter picks one
//   requester in IDLE. The grant then stays locked until that requester's beat
//   flagged req_last is accepted. Read beats push the requester index into a
//   tag FIFO. In-order memory responses pop that FIFO, which routes each
//   response back to the requester that issued the read.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/ready/we/last    per-requester beat handshake and attributes
//   req_addr, req_wdata        packed per-requester address / write data
//   rsp_valid, rsp_rdata       one-hot read-response valid, broadcast read data
//   mem_valid/ready/we         shared memory beat handshake
//   mem_addr, mem_wdata        shared memory address / write data
//   mem_rsp_valid/rdata        in-order memory read response (no backpressure)
//   grant_active, grant_idx    locked flag, current or last granted requester
//   err_rsp_unexp              sticky: response arrived with no outstanding read

module fm_port_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int TAG_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_we,
   input  logic [NUM_REQ-1:0]           req_last,
   input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [DATA_W-1:0]            rsp_rdata,
   output logic                         mem_valid,
   input  logic                         mem_ready,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wdata,
   input  logic                         mem_rsp_valid,
   input  logic [DATA_W-1:0]            mem_rsp_rdata,
   output logic                         grant_active,
   output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
   output logic                         err_rsp_unexp
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] TAG_FULL = CNT_W'(TAG_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]  tag_mem_q [TAG_DEPTH];
   logic [PTR_W-1:0]  tag_wr_q, tag_wr_d;
   logic [PTR_W-1:0]  tag_rd_q, tag_rd_d;
   logic [CNT_W-1:0]  tag_cnt_q, tag_cnt_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] addr_a  [NUM_REQ];
   logic [DATA_W-1:0] wdata_a [NUM_REQ];

   logic              sel_valid_s, sel_we_s, sel_last_s;
   logic              mem_valid_s, accept_s, push_s, pop_s;
   logic              pick_found_s;
   logic [IDX_W-1:0]  pick_idx_s, cand_s;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
   end

   // Pass-through from the granted requester; reads are held off while the tag FIFO is full.
   always_comb begin
      sel_valid_s = req_valid[grant_idx_q];
      sel_we_s    = req_we[grant_idx_q];
      sel_last_s  = req_last[grant_idx_q];
      req_ready   = {NUM_REQ{1'b0}};
      if (state_q == ST_LOCKED) begin
         // Registered count only: a pop in this cycle does not free a slot until the next one.
         mem_valid_s = sel_valid_s && (sel_we_s || (tag_cnt_q < TAG_FULL));
         mem_we      = sel_we_s;
         mem_addr    = addr_a[grant_idx_q];
         mem_wdata   = wdata_a[grant_idx_q];
      end else begin
         mem_valid_s = 1'b0;
         mem_we      = 1'b0;
         mem_addr    = {ADDR_W{1'b0}};
         mem_wdata   = {DATA_W{1'b0}};
      end
      accept_s = mem_valid_s && mem_ready;
      if (accept_s) begin
         req_ready[grant_idx_q] = 1'b1;
      end else begin
         req_ready = {NUM_REQ{1'b0}};
      end
      mem_valid = mem_valid_s;
   end

   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = rr_ptr_q;
      cand_s       = rr_ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_found_s && req_valid[cand_s]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = cand_s;
         end else begin
            pick_found_s = pick_found_s;
         end
         if (cand_s == LAST_IDX) begin
            cand_s = IDX_ZERO;
         end else begin
            cand_s = cand_s + IDX_ONE;
         end
      end
   end

   // Grant FSM next state: lock on a pick, release on acceptance of the last beat.
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found_s) begin
               state_d     = ST_LOCKED;
               grant_idx_d = pick_idx_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            if (accept_s && sel_last_s) begin
               state_d  = ST_IDLE;
               rr_ptr_d = (grant_idx_q == LAST_IDX) ? IDX_ZERO : (grant_idx_q + IDX_ONE);
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Tag FIFO bookkeeping and response routing; an empty-FIFO response only flags an error.
   always_comb begin
      push_s    = accept_s && !sel_we_s;
      pop_s     = mem_rsp_valid && (tag_cnt_q != CNT_ZERO);
      tag_wr_d  = push_s ? (tag_wr_q + PTR_ONE) : tag_wr_q;
      tag_rd_d  = pop_s  ? (tag_rd_q + PTR_ONE) : tag_rd_q;
      case ({push_s, pop_s})
         2'b10:   tag_cnt_d = tag_cnt_q + CNT_ONE;
         2'b01:   tag_cnt_d = tag_cnt_q - CNT_ONE;
         default: tag_cnt_d = tag_cnt_q;
      endcase
      err_d     = err_q | (mem_rsp_valid && (tag_cnt_q == CNT_ZERO));
      rsp_valid = {NUM_REQ{1'b0}};
      if (pop_s) begin
         rsp_valid[tag_mem_q[tag_rd_q]] = 1'b1;
      end else begin
         rsp_valid = {NUM_REQ{1'b0}};
      end
   end

   // State, pointer, FIFO and error registers; reset drops any grant and flushes the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         grant_idx_q <= IDX_ZERO;
         rr_ptr_q    <= IDX_ZERO;
         tag_wr_q    <= {PTR_W{1'b0}};
         tag_rd_q    <= {PTR_W{1'b0}};
         tag_cnt_q   <= CNT_ZERO;
         err_q       <= 1'b0;
         for (int i = 0; i < TAG_DEPTH; i++) begin
            tag_mem_q[i] <= IDX_ZERO;
         end
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         tag_wr_q    <= tag_wr_d;
         tag_rd_q    <= tag_rd_d;
         tag_cnt_q   <= tag_cnt_d;
         err_q       <= err_d;
         if (push_s) begin
            tag_mem_q[tag_wr_q] <= grant_idx_q;
         end
      end
   end

   assign grant_active  = (state_q == ST_LOCKED);
   assign grant_idx     = grant_idx_q;
   assign err_rsp_unexp = err_q;
   assign rsp_rdata     = mem_rsp_rdata;

endmodule

// File: tb/tb_fm_port_arbiter.sv
// tb_fm_port_arbiter
//   Scenario tasks drive requester beats and memory responses. Expected memory
//   beats and expected routed responses are pushed to queues as the stimulus is
//   issued. A negedge monitor pops and compares them whenever the DUT shows a
//   memory handshake or a response cycle.

module tb_fm_port_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int TAG_DEPTH = 8;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } beat_t;

   typedef struct packed {
      logic [NUM_REQ-1:0] onehot;
      logic [DATA_W-1:0]  data;
   } rsp_t;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req_valid, req_ready, req_we, req_last;
   logic [NUM_REQ*ADDR_W-1:0]  req_addr;
   logic [NUM_REQ*DATA_W-1:0]  req_wdata;
   logic [NUM_REQ-1:0]         rsp_valid;
   logic [DATA_W-1:0]          rsp_rdata;
   logic                       mem_valid, mem_ready, mem_we;
   logic [ADDR_W-1:0]          mem_addr;
   logic [DATA_W-1:0]          mem_wdata;
   logic                       mem_rsp_valid;
   logic [DATA_W-1:0]          mem_rsp_rdata;
   logic                       grant_active;
   logic [1:0]                 grant_idx;
   logic                       err_rsp_unexp;

   int    checks = 0;
   int    errors = 0;
   beat_t exp_beats[$];
   rsp_t  exp_rsps[$];
   int    pending_reads[$];
   beat_t mon_beat;
   rsp_t  mon_rsp;

   fm_port_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_last(req_last),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .grant_active(grant_active), .grant_idx(grant_idx), .err_rsp_unexp(err_rsp_unexp)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: compare every memory handshake and every response cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_valid && mem_ready) begin
            checks++;
            if (exp_beats.size() == 0) begin
               errors++;
               $display("FAIL mem_beat_unexpected got we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
            end else begin
               mon_beat = exp_beats.pop_front();
               if ({mem_we, mem_addr, mem_wdata} !== mon_beat) begin
                  errors++;
                  $display("FAIL mem_beat got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                           mem_we, mem_addr, mem_wdata, mon_beat.we, mon_beat.addr, mon_beat.data);
               end
            end
         end
         if (mem_rsp_valid) begin
            checks++;
            if (exp_rsps.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected got rsp_valid=%b", rsp_valid);
            end else begin
               mon_rsp = exp_rsps.pop_front();
               if (rsp_valid !== mon_rsp.onehot || rsp_rdata !== mon_rsp.data) begin
                  errors++;
                  $display("FAIL rsp_route got valid=%b data=%h expected valid=%b data=%h",
                           rsp_valid, rsp_rdata, mon_rsp.onehot, mon_rsp.data);
               end
            end
         end else begin
            checks++;
            if (rsp_valid !== 4'b0000) begin
               errors++;
               $display("FAIL rsp_spurious got rsp_valid=%b expected 0000", rsp_valid);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      req_valid     = 4'b0000;
      req_we        = 4'b0000;
      req_last      = 4'b0000;
      req_addr      = {(NUM_REQ*ADDR_W){1'b0}};
      req_wdata     = {(NUM_REQ*DATA_W){1'b0}};
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 64'h0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_beats.delete();
      exp_rsps.delete();
      pending_reads.delete();
      rst_n = 1'b1;
   endtask

   task automatic rsp_begin(input logic [DATA_W-1:0] d);
      rsp_t e;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = d;
      e.data = d;
      if (pending_reads.size() > 0) begin
         e.onehot = 4'b0001 << pending_reads.pop_front();
      end else begin
         e.onehot = 4'b0000;
      end
      exp_rsps.push_back(e);
   endtask

   task automatic rsp_end();
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 64'h0;
   endtask

   // One burst from requester r; reports the wait before beat 0 and the waits between later beats.
   task automatic send_burst(input int r, input int n, input logic we, input logic [ADDR_W-1:0] base,
                             output int first_wait, output int extra_wait);
      int    w;
      beat_t b;
      first_wait = 0;
      extra_wait = 0;
      for (int k = 0; k < n; k++) begin
         b.we   = we;
         b.addr = base + 32'(k * 8);
         b.data = {base, 32'(k)};
         req_valid[r] = 1'b1;
         req_we[r]    = we;
         req_last[r]  = (k == n - 1) ? 1'b1 : 1'b0;
         req_addr[r*ADDR_W +: ADDR_W]  = b.addr;
         req_wdata[r*DATA_W +: DATA_W] = b.data;
         exp_beats.push_back(b);
         if (we == 1'b0) pending_reads.push_back(r);
         w = 0;
         @(negedge clk);
         while (!req_ready[r] && w < 40) begin
            w++;
            @(posedge clk); #1;
            @(negedge clk);
         end
         if (!req_ready[r]) begin
            checks++;
            errors++;
            $display("FAIL burst_timeout requester %0d beat %0d got no req_ready within 40 cycles", r, k);
         end
         if (k == 0) first_wait = w;
         else        extra_wait += w;
         @(posedge clk); #1;
      end
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
   endtask

   // Hold single-beat writes on every masked requester; order packs the grant sequence, 2 bits each.
   task automatic check_rr(input logic [3:0] mask, input int n, input logic [15:0] order);
      logic [1:0] g;
      beat_t      b;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (mask[i]) begin
            req_valid[i] = 1'b1;
            req_we[i]    = 1'b1;
            req_last[i]  = 1'b1;
            req_addr[i*ADDR_W +: ADDR_W]  = 32'h0000_1000 + 32'(i * 16);
            req_wdata[i*DATA_W +: DATA_W] = {32'hC0DE_0000, 32'(i)};
         end
      end
      for (int j = 0; j < n; j++) begin
         g      = order[2*j +: 2];
         b.we   = 1'b1;
         b.addr = 32'h0000_1000 + 32'(g) * 32'd16;
         b.data = {32'hC0DE_0000, 30'd0, g};
         exp_beats.push_back(b);
      end
      for (int c = 0; c < 2 * n; c++) begin
         @(negedge clk);
         checks++;
         if (c % 2 == 0) begin
            if (grant_active !== 1'b0 || req_ready !== 4'b0000) begin
               errors++;
               $display("FAIL rr_idle cycle %0d got active=%0b ready=%b expected 0 0000", c, grant_active, req_ready);
            end
         end else begin
            g = order[(c/2)*2 +: 2];
            if (grant_active !== 1'b1 || grant_idx !== g || req_ready !== (4'b0001 << g)) begin
               errors++;
               $display("FAIL rr_grant cycle %0d got active=%0b idx=%0d ready=%b expected 1 %0d %b",
                        c, grant_active, grant_idx, req_ready, g, 4'b0001 << g);
            end
         end
         @(posedge clk); #1;
      end
      req_valid = 4'b0000;
      req_last  = 4'b0000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({grant_active, grant_idx, req_ready, mem_valid, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_rdata, err_rsp_unexp} !== '0) begin
         errors++;
         $display("FAIL reset_values got active=%0b idx=%0d ready=%b mem_valid=%0b err=%0b expected all 0",
                  grant_active, grant_idx, req_ready, mem_valid, err_rsp_unexp);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (grant_active !== 1'b0 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got active=%0b mem_valid=%0b expected 0 0", grant_active, mem_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_burst();
      int fw, ew;
      send_burst(0, 4, 1'b1, 32'h0000_0100, fw, ew);
      checks++;
      if (fw !== 1) begin
         errors++;
         $display("FAIL grant_latency got %0d cycles expected 1", fw);
      end
      checks++;
      if (ew !== 0) begin
         errors++;
         $display("FAIL burst_consecutive got %0d stall cycles expected 0", ew);
      end
      @(negedge clk);
      checks++;
      if (grant_active !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_last got active=%0b expected 0", grant_active);
      end
      @(posedge clk); #1;
      // rr_ptr is now 1: requester 1 wins over requester 0, then 0 gets its turn.
      check_rr(4'b0011, 2, 16'h0001);
   endtask

   task automatic test_round_robin();
      apply_reset();
      check_rr(4'b1111, 5, 16'h00E4);
   endtask

   task automatic test_tag_full();
      int    fw, ew;
      beat_t b;
      send_burst(2, 8, 1'b0, 32'h0000_2000, fw, ew);
      checks++;
      if (ew !== 0) begin
         errors++;
         $display("FAIL read_burst_stall got %0d stall cycles expected 0", ew);
      end
      b.we   = 1'b0;
      b.addr = 32'h0000_2040;
      b.data = {32'h0000_2040, 32'd8};
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b0;
      req_last[2]  = 1'b1;
      req_addr[2*ADDR_W +: ADDR_W]  = b.addr;
      req_wdata[2*DATA_W +: DATA_W] = b.data;
      exp_beats.push_back(b);
      pending_reads.push_back(2);
      @(negedge clk);
      @(posedge clk); #1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (grant_active !== 1'b1 || req_ready[2] !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL tag_full_block got active=%0b ready=%0b mem_valid=%0b expected 1 0 0",
                     grant_active, req_ready[2], mem_valid);
         end
         @(posedge clk); #1;
      end
      rsp_begin(64'hAAAA_0000_0000_0000);
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b0) begin
         errors++;
         $display("FAIL tag_full_no_bypass got ready=%0b expected 0", req_ready[2]);
      end
      @(posedge clk); #1;
      rsp_end();
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b1) begin
         errors++;
         $display("FAIL tag_full_release got ready=%0b expected 1", req_ready[2]);
      end
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      req_last[2]  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         rsp_begin(64'hAAAA_0000_0000_0001 + 64'(k));
         @(posedge clk); #1;
      end
      rsp_end();
   endtask

   task automatic test_rsp_routing();
      int fw, ew;
      send_burst(1, 3, 1'b0, 32'h0000_3000, fw, ew);
      fork
         send_burst(3, 4, 1'b1, 32'h0000_4000, fw, ew);
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
               rsp_begin(64'h5555_0000_0000_0000 + 64'(k));
               @(negedge clk);
               checks++;
               if (grant_active !== 1'b1 || grant_idx !== 2'd3) begin
                  errors++;
                  $display("FAIL rsp_during_other_grant got active=%0b idx=%0d expected 1 3", grant_active, grant_idx);
               end
               @(posedge clk); #1;
            end
            rsp_end();
         end
      join
      checks++;
      if (fw !== 1 || ew !== 0) begin
         errors++;
         $display("FAIL req3_burst_timing got wait=%0d stalls=%0d expected 1 0", fw, ew);
      end
   endtask

   task automatic test_reset_mid_burst();
      int    fw, ew;
      beat_t b;
      // Leaves one read outstanding and moves rr_ptr to 2.
      send_burst(1, 1, 1'b0, 32'h0000_6000, fw, ew);
      b.we   = 1'b1;
      b.addr = 32'h0000_7000;
      b.data = {32'h0000_7000, 32'd0};
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b1;
      req_last[2]  = 1'b0;
      req_addr[2*ADDR_W +: ADDR_W]  = b.addr;
      req_wdata[2*DATA_W +: DATA_W] = b.data;
      exp_beats.push_back(b);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL mid_burst_beat1 got ready=%b expected 0100", req_ready);
      end
      @(posedge clk); #1;
      req_addr[2*ADDR_W +: ADDR_W]  = 32'h0000_7008;
      req_wdata[2*DATA_W +: DATA_W] = {32'h0000_7000, 32'd1};
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant_active, grant_idx, req_ready, mem_valid, mem_we, mem_addr, mem_wdata,
           rsp_valid, rsp_rdata, err_rsp_unexp} !== '0) begin
         errors++;
         $display("FAIL reset_mid_burst got active=%0b idx=%0d ready=%b mem_valid=%0b addr=%h expected all 0",
                  grant_active, grant_idx, req_ready, mem_valid, mem_addr);
      end
      idle_inputs();
      pending_reads.delete();
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      // With rr_ptr back at 0, requester 0 wins before requester 2.
      check_rr(4'b0101, 2, 16'h0008);
   endtask

   task automatic test_unexp_rsp();
      @(negedge clk);
      checks++;
      if (err_rsp_unexp !== 1'b0) begin
         errors++;
         $display("FAIL err_initial got %0b expected 0", err_rsp_unexp);
      end
      @(posedge clk); #1;
      rsp_begin(64'hDEAD_BEEF_0000_0005);
      @(posedge clk); #1;
      rsp_end();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (err_rsp_unexp !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky cycle %0d got %0b expected 1", c, err_rsp_unexp);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (err_rsp_unexp !== 1'b0) begin
         errors++;
         $display("FAIL err_reset_clear got %0b expected 0", err_rsp_unexp);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_round_robin();
      test_tag_full();
      test_rsp_routing();
      test_reset_mid_burst();
      test_unexp_rsp();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_beats.size() != 0 || exp_rsps.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got beats=%0d rsps=%0d left expected 0 0", exp_beats.size(), exp_rsps.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
